// File: rtl/mux7_arb_pkg.sv
// Shared types and helpers for the 7-way round-robin mux arbiter.
// Requester count, select width, FSM states and index wrap.
package mux7_arb_pkg;

  localparam int N_REQ = 7;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  function automatic logic [SEL_W-1:0] next_idx(
    input logic [SEL_W-1:0] i
  );
    if (i == SEL_W'(N_REQ - 1))
      return '0;
    return i + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick7.sv
// Combinational round-robin pick over 7 requesters.
// Scans upward from ptr with 6->0 wrap; first set bit wins.
import mux7_arb_pkg::*;

module rr_pick7 (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    logic [SEL_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    j     = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
      j = next_idx(j);
    end
  end

endmodule

// File: rtl/mux7_rr_arbiter.sv
// Round-robin arbiter sharing a 7:1 one-bit mux channel.
// Bounded hold quantum, early release, registered data bit.
import mux7_arb_pkg::*;

module mux7_rr_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             data_out
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_n;
  logic [N_REQ-1:0] grant_n;
  logic             busy_n;
  logic             term;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  assign term = (cnt == '0) || !req[sel];

  // On termination the holder drops to lowest priority.
  assign pick_ptr =
    (state == HOLD) ? next_idx(sel) : ptr;

  rr_pick7 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    sel_n   = sel;
    busy_n  = busy;
    grant_n = grant;
    unique case (1'b1)
      (state == IDLE): begin
        if (pick_found) begin
          state_n = HOLD;
          sel_n   = pick_idx;
          busy_n  = 1'b1;
          cnt_n   = CNT_LOAD;
          grant_n = N_REQ'(1) << pick_idx;
        end
      end
      (state == HOLD): begin
        if (!term) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          ptr_n = next_idx(sel);
          if (pick_found) begin
            sel_n   = pick_idx;
            cnt_n   = CNT_LOAD;
            grant_n = N_REQ'(1) << pick_idx;
          end else begin
            state_n = IDLE;
            sel_n   = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            grant_n = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      grant    <= '0;
      data_out <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      busy     <= busy_n;
      grant    <= grant_n;
      data_out <= busy_n ? data_in[sel_n] : 1'b0;
    end
  end

endmodule

// File: doc/mux7_rr_arbiter.md
Name: mux7_rr_arbiter

Overview:
- Round-robin arbiter that shares the 7:1 one-bit mux channel among 7 requesters.
- Drives the mux select lines {s2,s1,s0} and a one-hot grant vector.
- Holds each grant for a bounded quantum, with early release, and registers the selected data bit.
- Sits between the requester sources (switches, or upstream blocks) and the shared mux / LEDR output path.

Parameters:
- HOLD_CYCLES, 4: maximum consecutive cycles one requester keeps the channel. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2**CNT_W > HOLD_CYCLES-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  7  request per requester; req[i] high means requester i wants the channel.
- data_in  input  7  mux data inputs; data_in[i] is the bit owned by requester i.
- grant  output  7  one-hot grant; all zero when idle.
- sel  output  3  mux select {s2,s1,s0} = index of the granted requester. Encodings 0..6 only; 3'b111 is never driven.
- busy  output  1  high while any grant is active.
- data_out  output  1  registered copy of data_in[sel] while granted; 0 otherwise.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; grant=0, sel=0, busy=0, data_out=0.
  - Internal ptr=0, cnt=0.
  - Reset asserted mid-grant aborts the grant immediately, with no handoff.
- States: IDLE, HOLD.
- Pick function (combinational): scan req starting at index ptr, ascending, wrapping 6->0. Result is the first set bit, plus a found flag.
- IDLE:
  - If any req bit is set at the clock edge: enter HOLD, set grant[idx]=1, sel=idx, busy=1, cnt=HOLD_CYCLES-1.
  - Latency from req rising to grant visible is 1 cycle.
  - Otherwise remain in IDLE with all outputs at their reset values.
- HOLD, evaluated at each edge:
  - Term condition: cnt==0, or req[sel]==0 (early release).
  - Not terminating: cnt<=cnt-1; grant and sel unchanged.
  - Terminating: ptr<=(sel==6)?0:sel+1, then run the pick with the new ptr in the same cycle.
  - Found (the current holder is included, at lowest priority): back-to-back handoff with no idle bubble. Load grant, sel and cnt for the new winner; busy stays 1.
  - Not found: go to IDLE, grant=0, sel=0, busy=0.
- A grant held with req continuously high lasts exactly HOLD_CYCLES cycles. HOLD_CYCLES=1 gives a new arbitration every cycle.
- A sole requester holding req high is re-granted to itself after each quantum. grant stays continuously high across the boundary; cnt reloads.
- Early release: the cycle in which req[sel] is sampled low is still a granted cycle. The grant drops, or hands off, at that edge.
- A requester raising req mid-quantum waits; current grants are never preempted.
- data_out: at every edge, data_out <= busy_next ? data_in[sel_next] : 0. data_out therefore tracks the granted bit with 1 cycle latency relative to data_in and is aligned with grant.
- Invariants:
  - grant is zero or one-hot.
  - grant[sel]==1 whenever busy.
  - sel<=6 always.

Decomposition:
- Package mux7_arb_pkg holds:
  - N_REQ=7 and SEL_W=3.
  - State enum {IDLE, HOLD}.
  - Function next_idx(i), giving wrap 6->0.
- One sub-module, rr_pick7: purely combinational. Inputs req[6:0] and ptr[2:0]; outputs found and idx[2:0].
- The arbiter holds the FSM, counter, ptr and data register.

Test Plan:
- Reset: req=7'h7F, reset_n=0 -> grant=0, sel=0, busy=0, data_out=0. Release reset -> next edge grant=7'h01, sel=0.
- Quantum: HOLD_CYCLES=4, req=7'b0000101 held -> grant=0x01 for 4 cycles, then 0x04 (sel=2) for 4 cycles, then 0x01 again. busy stays 1 throughout, with no gap.
- Early release: req[3] alone granted, req[3] dropped on its 2nd granted cycle -> grant=0 and busy=0 on the following cycle. ptr=4, so the next req=7'h09 grants index 0 (scan order 4,5,6,0,...) before index 3.
- Wrap: req[6] granted and quantum expires with req=7'b1000001 -> next grant index 0 (sel=0), not 6.
- Data path: requester 5 granted, data_in[5] toggles 1,0,1 -> data_out shows 1,0,1 one cycle later. Toggling data_in[4] leaves data_out unaffected. data_out=0 when idle.
- Async reset mid-HOLD (cnt=2): pulse reset_n low between edges -> outputs clear immediately, without waiting for a clock edge. After release, arbitration restarts at ptr=0.
